ccff_bitstream_loader: RTL
==========================

Name: ccff_bitstream_loader

Overview:
- Upstream stage of the switch-block configuration chain.
- Accepts configuration words from the bitstream host over a valid/ready stream and serialises them one bit per prog_clk onto the chain's ccff_head.
- Gates chain shifting with chain_en and signals completion after exactly CHAIN_LEN bits.
- One instance drives one chain segment; a 5-track sb tile with 4x size10 and 4x size8 muxes has 4*8 + 4*6 = 56 bits.

Parameters:
- WORD_W, 32, width of each host configuration word.
- CHAIN_LEN, 56, number of configuration bits in the driven chain; must be >= 1.
- CNT_W, $clog2(CHAIN_LEN+1), width of the bit counter.

Ports:
- prog_clk  in  1  configuration clock; all state on rising edge.
- pReset  in  1  asynchronous reset, active-low; the block is in reset while low.
- start  in  1  begin a load; sampled only in IDLE.
- abort  in  1  terminate the load; highest priority after reset.
- s_data  in  WORD_W  configuration word; bit 0 is shifted first.
- s_valid  in  1  s_data is valid.
- s_ready  out  1  the loader accepts s_data this cycle.
- ccff_head  out  1  serial bit into the chain head.
- chain_en  out  1  the chain shifts on this edge; ccff_head is meaningful only when high.
- busy  out  1  high in LOAD and SHIFT.
- done  out  1  one-cycle pulse after the last bit has been shifted.
- bit_count  out  CNT_W  number of bits shifted so far in the current load.

Behaviour:
- Reset (pReset low, asynchronous):
  - state is IDLE.
  - s_ready, ccff_head, chain_en, busy and done are 0.
  - bit_count and the word register are 0.
  - Reset mid-load drops the load immediately; the chain content is undefined and software must reload.
- States: IDLE, LOAD, SHIFT, DONE.
- IDLE:
  - s_ready=0 and chain_en=0.
  - If start=1, clear bit_count and go to LOAD.
  - start in any other state is ignored.
- LOAD:
  - busy=1 and s_ready=1.
  - On s_valid&s_ready, capture s_data, set the bit index to 0, and go to SHIFT.
  - chain_en=0 while waiting; the chain holds.
- SHIFT:
  - busy=1, chain_en=1, ccff_head=word[idx].
  - bit_count increments on each SHIFT edge.
  - On the last chain bit (bit_count==CHAIN_LEN-1): go to DONE. s_ready=0; no word is taken; the unused upper bits of the current word are discarded.
  - On the last bit of the word with chain bits remaining: s_ready=1.
    - If a word is accepted in that cycle, stay in SHIFT and emit new word[0] next cycle, so there is no bubble.
    - Otherwise go to LOAD (a stall).
  - Otherwise idx increments and s_ready=0.
- DONE: done=1 for one cycle, busy=0, then IDLE. bit_count holds at CHAIN_LEN until the next start.
- Latency: start edge k leads to s_ready from cycle k+1. A word accepted at edge j puts its first bit on ccff_head in cycle j+1. With no stalls, done asserts exactly CHAIN_LEN cycles after the first SHIFT cycle.
- abort=1 in any state:
  - Next state is IDLE, with chain_en=0 and s_ready=0 in the following cycle.
  - No done pulse is produced.
  - bit_count holds its value for debug.
  - abort takes precedence over a simultaneous handshake; that word is not consumed.
- Word sizes: CHAIN_LEN < WORD_W needs one word. An exact multiple of WORD_W discards no bits.
- The upstream host must hold s_data stable while s_valid=1 and s_ready=0.

Decomposition:
- Shared package ccff_cfg_pkg:
  - Enum ccff_ld_state_t {IDLE, LOAD, SHIFT, DONE}.
  - Localparams for per-tile chain lengths (SB_1_1_CHAIN_LEN=56).
- One sub-module, ccff_piso: a WORD_W parallel-in/serial-out register with load, shift and last_bit outputs.
- The FSM and counters stay in the top level.

Test Plan:
- Reset: pReset=0 asynchronously mid-SHIFT at bit_count=20 -> chain_en, busy, s_ready and done are 0 within the same cycle; after release, state is IDLE and bit_count=0.
- Back-to-back load, CHAIN_LEN=56, WORD_W=32:
  - Stimulus: start, then words 0xA5A5_0F0F and 0x00FF_1234 with s_valid always high.
  - Required: 56 consecutive chain_en cycles, ccff_head sequence equal to the LSB-first bits of word0 then bits 0..23 of word1, done pulse 1 cycle after the last bit, bit_count=56.
- Stall: s_valid dropped for 5 cycles after word0 -> chain_en=0 for those 5 cycles, busy=1, and the serial stream is identical to the no-stall case.
- Abort at bit_count=40 with s_valid=1 -> IDLE next cycle, no done, s_ready=0, the pending word is not accepted, bit_count=40.
- Short chain, CHAIN_LEN=8, one word 0x0000_00C3 -> ccff_head emits 1,1,0,0,0,0,1,1 in 8 cycles, done, and the upper 24 bits are discarded.
- start asserted during SHIFT and a s_valid pulse while IDLE -> both are ignored, no handshake occurs, and the serial output is unchanged.

Source files
------------

// File: rtl/ccff_cfg_pkg.sv
// Shared state encoding and per-tile chain lengths for configuration-chain loaders.
// Every loader and its bench import these, so they agree on encodings and lengths.
package ccff_cfg_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    LOAD  = 2'd1,
    SHIFT = 2'd2,
    DONE  = 2'd3
  } ccff_ld_state_t;

  // 5-track sb tile: 4x size10 muxes (8 bits each) + 4x size8 muxes (6 bits each)
  localparam int SB_1_1_CHAIN_LEN = 56;

endpackage

// File: rtl/ccff_bitstream_loader_if.sv
// Host-to-loader configuration word stream (valid/ready).
// s_data must hold stable while s_valid is high and s_ready is low.
interface ccff_bitstream_loader_if #(
  parameter int WORD_W = 32
);
  logic [WORD_W-1:0] s_data;
  logic              s_valid;
  logic              s_ready;

  modport master (output s_data, output s_valid, input s_ready);
  modport slave  (input s_data, input s_valid, output s_ready);
endinterface

// File: rtl/ccff_piso.sv
// Parallel-in/serial-out word register; bit 0 leaves first, new word visible the cycle after load.
// No backpressure of its own: load wins over shift, and the controller decides both.
module ccff_piso #(
  parameter int WORD_W = 32
) (
  input  logic              prog_clk,
  input  logic              pReset,
  input  logic              load,
  input  logic              shift,
  input  logic [WORD_W-1:0] din,
  output logic              sout,
  output logic              last_bit,
  output logic              pre_last
);
  localparam int IDX_W   = (WORD_W > 1) ? $clog2(WORD_W) : 1;
  localparam int PRE_IDX = (WORD_W > 1) ? WORD_W - 2 : 0;

  logic [WORD_W-1:0] sreg;
  logic [IDX_W-1:0]  idx;

  always_ff @(posedge prog_clk or negedge pReset) begin
    if (!pReset) begin
      sreg <= '0;
      idx  <= '0;
    end else if (load) begin
      sreg <= din;
      idx  <= '0;
    end else if (shift) begin
      sreg <= sreg >> 1;
      idx  <= idx + 1'b1;
    end
  end

  assign sout     = sreg[0];
  assign last_bit = (idx == IDX_W'(WORD_W - 1));
  // Lets the controller raise a registered s_ready exactly on the word's last bit
  assign pre_last = (WORD_W > 1) && (idx == IDX_W'(PRE_IDX));

endmodule

// File: rtl/ccff_bitstream_loader.sv
// Serialises host configuration words onto ccff_head, one bit per prog_clk, for CHAIN_LEN bits.
// s_ready opens only in LOAD or on a word's last bit, so a waiting host stalls the chain.
module ccff_bitstream_loader
  import ccff_cfg_pkg::*;
#(
  parameter int WORD_W    = 32,
  parameter int CHAIN_LEN = SB_1_1_CHAIN_LEN,
  parameter int CNT_W     = $clog2(CHAIN_LEN + 1)
) (
  input  logic                  prog_clk,
  input  logic                  pReset,
  input  logic                  start,
  input  logic                  abort,
  ccff_bitstream_loader_if.slave s,
  output logic                  ccff_head,
  output logic                  chain_en,
  output logic                  busy,
  output logic                  done,
  output logic [CNT_W-1:0]      bit_count
);
  localparam logic [CNT_W-1:0] LAST_CNT     = CNT_W'(CHAIN_LEN - 1);
  localparam bit               ONE_BIT_WORD = (WORD_W == 1);

  ccff_ld_state_t   state;
  logic             s_ready_q;
  logic             accept;
  logic             piso_shift;
  logic             last_bit;
  logic             pre_last;
  logic [CNT_W-1:0] cnt_inc;

  assign cnt_inc    = bit_count + 1'b1;
  assign accept     = s.s_valid && s_ready_q && !abort;
  assign piso_shift = (state == SHIFT) && !abort && !accept;
  assign s.s_ready  = s_ready_q;

  ccff_piso #(.WORD_W(WORD_W)) u_piso (
    .prog_clk (prog_clk),
    .pReset   (pReset),
    .load     (accept),
    .shift    (piso_shift),
    .din      (s.s_data),
    .sout     (ccff_head),
    .last_bit (last_bit),
    .pre_last (pre_last)
  );

  always_ff @(posedge prog_clk or negedge pReset) begin
    if (!pReset) begin
      state     <= IDLE;
      s_ready_q <= 1'b0;
      chain_en  <= 1'b0;
      busy      <= 1'b0;
      done      <= 1'b0;
      bit_count <= '0;
    end else begin
      done <= 1'b0;
      if (abort) begin
        // bit_count is left alone so software can see how far the load got
        state     <= IDLE;
        s_ready_q <= 1'b0;
        chain_en  <= 1'b0;
        busy      <= 1'b0;
      end else begin
        case (state)
          IDLE: begin
            if (start) begin
              bit_count <= '0;
              state     <= LOAD;
              s_ready_q <= 1'b1;
              busy      <= 1'b1;
            end
          end
          LOAD: begin
            if (accept) begin
              state     <= SHIFT;
              chain_en  <= 1'b1;
              s_ready_q <= ONE_BIT_WORD && (bit_count != LAST_CNT);
            end
          end
          SHIFT: begin
            bit_count <= cnt_inc;
            if (bit_count == LAST_CNT) begin
              state     <= DONE;
              chain_en  <= 1'b0;
              busy      <= 1'b0;
              done      <= 1'b1;
              s_ready_q <= 1'b0;
            end else if (last_bit) begin
              if (accept) begin
                s_ready_q <= ONE_BIT_WORD && (cnt_inc != LAST_CNT);
              end else begin
                state     <= LOAD;
                chain_en  <= 1'b0;
                s_ready_q <= 1'b1;
              end
            end else begin
              // no word is requested if the chain ends before this word does
              s_ready_q <= pre_last && (cnt_inc != LAST_CNT);
            end
          end
          DONE:    state <= IDLE;
          default: state <= IDLE;
        endcase
      end
    end
  end

endmodule
